// File: rtl/uart_rx_byte_pkg.sv
// Shared definitions for the UART 8N1 receiver: FSM state encoding and default timing.
package uart_rx_byte_pkg;

   localparam int unsigned CLKS_PER_BIT_DEFAULT = 87;
   localparam int unsigned SYNC_STAGES_DEFAULT  = 2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BRK   = 3'd4
   } rx_state_e;

endpackage

// File: rtl/uart_rx_byte_rx_sync.sv
// Multi-stage shift synchroniser for the asynchronous rx line; resets to the idle (high) level.
module rx_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_byte.sv
// UART 8N1 receiver: start-bit glitch rejection, mid-bit sampling, framing-error and break
// handling, and a one-byte holding register behind a valid/ready handshake.
module uart_rx_byte
   import uart_rx_byte_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEFAULT
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       rx_serial,
   output logic [7:0] o_data,
   output logic       o_valid,
   input  logic       i_ready,
   output logic       o_frame_err,
   output logic       o_overrun,
   output logic       o_busy,
   output rx_state_e  o_dbg_state
);

   // Handshake: o_data is accepted on any cycle where o_valid & i_ready; while o_valid is high
   // and i_ready low, o_data and o_valid stay put; i_ready with o_valid low is ignored.

   localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
   localparam int unsigned HALF = CLKS_PER_BIT / 2;
   localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
   localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

   logic            rxs;
   logic            rxs_q;
   rx_state_e       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            deliver_q, deliver_d;
   logic [7:0]      data_q, data_d;
   logic            valid_q, valid_d;
   logic            ferr_q, ferr_d;
   logic            ovr_q, ovr_d;

   rx_sync #(
      .STAGES (SYNC_STAGES)
   ) u_rx_sync (
      .clk_i (CLK),
      .rst_i (RST),
      .d_i   (rx_serial),
      .q_o   (rxs)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         rxs_q     <= 1'b1;
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         deliver_q <= 1'b0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         rxs_q     <= rxs;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         deliver_q <= deliver_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         ovr_q     <= ovr_d;
      end
   end

   // Frame FSM: the stop bit is judged at its midpoint so IDLE can catch a back-to-back start edge.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      deliver_d = 1'b0;
      ferr_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rxs_q && !rxs) begin
               cnt_d   = '0;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d = '0;
               if (!rxs) begin
                  idx_d   = '0;
                  state_d = ST_DATA;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d          = '0;
               shift_d[idx_q] = rxs;
               idx_d          = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
                  state_d = ST_STOP;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (rxs) begin
                  deliver_d = 1'b1;
                  state_d   = ST_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = ST_BRK;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_BRK: begin
            if (rxs) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // A byte arriving into a full, unconsumed holding register is dropped and flagged.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ovr_d   = 1'b0;
      if (deliver_q) begin
         if (!valid_q || i_ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && i_ready) begin
         valid_d = 1'b0;
      end
   end

   assign o_data      = data_q;
   assign o_valid     = valid_q;
   assign o_frame_err = ferr_q;
   assign o_overrun   = ovr_q;
   assign o_busy      = (state_q != ST_IDLE);
   assign o_dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
`timescale 1ns/1ps
// Bench for uart_rx_byte: drives 8N1 frames on rx_serial and scores deliveries, error pulses
// and the handshake against a byte-level model of what the receiver should hand over.
module tb_uart_rx_byte;
   import uart_rx_byte_pkg::*;

   localparam int CPB  = 87;
   localparam int SYNC = 2;
   localparam int HALF = CPB / 2;
   localparam int LAT  = SYNC + 1 + HALF + 9 * CPB;

   // clock / reset and DUT
   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       rx_serial = 1'b1;
   logic       i_ready = 1'b0;
   logic [7:0] o_data;
   logic       o_valid, o_frame_err, o_overrun, o_busy;
   rx_state_e  o_dbg_state;

   always #50 CLK = ~CLK;

   uart_rx_byte #(
      .CLKS_PER_BIT (CPB),
      .SYNC_STAGES  (SYNC)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .rx_serial   (rx_serial),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_frame_err (o_frame_err),
      .o_overrun   (o_overrun),
      .o_busy      (o_busy),
      .o_dbg_state (o_dbg_state)
   );

   // monitor: records accepted bytes and counts flag cycles
   int         cyc = 0;
   logic [7:0] acc_q[$];
   int         n_valid_cyc = 0, n_ferr = 0, n_ovr = 0, n_both = 0, n_unstable = 0;
   int         valid_rise_cyc = 0;
   logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_rst = 1'b1;
   logic [7:0] prev_data = 8'h00;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (o_valid && i_ready) acc_q.push_back(o_data);
      if (o_valid) n_valid_cyc++;
      if (o_valid && !prev_valid) valid_rise_cyc = cyc;
      if (o_frame_err) n_ferr++;
      if (o_overrun) n_ovr++;
      if (o_frame_err && o_overrun) n_both++;
      if (!prev_rst && prev_valid && !prev_ready && (!o_valid || o_data != prev_data)) n_unstable++;
      prev_valid = o_valid;
      prev_ready = i_ready;
      prev_rst   = RST;
      prev_data  = o_data;
   end

   // scoreboard and reference model
   logic [7:0] exp_q[$];
   int         exp_ferr = 0, exp_ovr = 0;
   bit         m_full = 1'b0;
   logic [7:0] m_data = 8'h00;
   int         scored = 0;
   int         n_checks = 0, n_fail = 0;
   int         pin_fall_cyc = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_frame(input logic [7:0] b, input bit stop_ok);
      if (!stop_ok) begin
         exp_ferr++;
      end else if (!m_full) begin
         m_full = 1'b1;
         m_data = b;
         exp_q.push_back(b);
      end else begin
         exp_ovr++;
      end
   endtask

   task automatic score_all(input string tag);
      check_eq({tag, "_count"}, acc_q.size(), exp_q.size());
      for (int i = scored; i < acc_q.size() && i < exp_q.size(); i++) begin
         check_eq({tag, "_byte"}, acc_q[i], exp_q[i]);
      end
      scored = acc_q.size();
   endtask

   // driver tasks
   task automatic wait_clks(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic uart_write_byte(input logic [7:0] b, input bit stop_bit);
      rx_serial    = 1'b0;
      pin_fall_cyc = cyc;
      wait_clks(CPB);
      for (int i = 0; i < 8; i++) begin
         rx_serial = b[i];
         wait_clks(CPB);
      end
      rx_serial = stop_bit;
      wait_clks(CPB);
   endtask

   task automatic pulse_ready();
      i_ready = 1'b1;
      wait_clks(1);
      i_ready = 1'b0;
      m_full  = 1'b0;
   endtask

   task automatic wait_valid(input string tag, input int limit);
      int t = 0;
      while (!o_valid && t < limit) begin
         wait_clks(1);
         t++;
      end
      check_eq(tag, o_valid, 1'b1);
   endtask

   initial begin
      #8_000_000;
      $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      int         base_valid;
      int         lat;
      logic [7:0] rb;
      bit         rstop;

      // reset
      RST = 1'b1;
      wait_clks(4);
      check_eq("rst_data", o_data, 8'h00);
      check_eq("rst_valid", o_valid, 1'b0);
      check_eq("rst_ferr", o_frame_err, 1'b0);
      check_eq("rst_ovr", o_overrun, 1'b0);
      check_eq("rst_busy", o_busy, 1'b0);
      check_eq("rst_state", o_dbg_state, ST_IDLE);
      RST = 1'b0;
      wait_clks(10);

      // single byte, consumer always ready
      i_ready    = 1'b1;
      base_valid = n_valid_cyc;
      uart_write_byte(8'hA5, 1'b1);
      model_frame(8'hA5, 1'b1);
      m_full = 1'b0;
      wait_clks(5);
      lat = valid_rise_cyc - pin_fall_cyc;
      check_eq("a5_valid_cycles", n_valid_cyc - base_valid, 1);
      check_eq("a5_latency_in_window", (lat >= LAT - 1 && lat <= LAT + 1), 1'b1);
      check_eq("a5_ferr", n_ferr, exp_ferr);
      check_eq("a5_ovr", n_ovr, exp_ovr);
      check_eq("a5_busy", o_busy, 1'b0);
      score_all("a5");

      // three back-to-back frames, consumer pulses ready after each delivery
      i_ready = 1'b0;
      fork
         begin
            uart_write_byte(8'h00, 1'b1);
            uart_write_byte(8'h01, 1'b1);
            uart_write_byte(8'h02, 1'b1);
         end
         begin
            for (int k = 0; k < 3; k++) begin
               wait_valid("b2b_valid_seen", 1500);
               pulse_ready();
            end
         end
      join
      for (int k = 0; k < 3; k++) begin
         model_frame(8'(k), 1'b1);
         m_full = 1'b0;
      end
      wait_clks(5);
      check_eq("b2b_ovr", n_ovr, exp_ovr);
      check_eq("b2b_ferr", n_ferr, exp_ferr);
      score_all("b2b");

      // overrun: two frames, nobody consumes
      uart_write_byte(8'h3C, 1'b1);
      uart_write_byte(8'hC3, 1'b1);
      model_frame(8'h3C, 1'b1);
      model_frame(8'hC3, 1'b1);
      wait_clks(5);
      check_eq("ovr_valid", o_valid, 1'b1);
      check_eq("ovr_data", o_data, m_data);
      check_eq("ovr_pulses", n_ovr, exp_ovr);
      check_eq("ovr_ferr", n_ferr, exp_ferr);
      pulse_ready();
      wait_clks(2);
      check_eq("ovr_drained", o_valid, 1'b0);
      score_all("ovr");

      // start-bit glitch
      base_valid = n_valid_cyc;
      rx_serial  = 1'b0;
      wait_clks(20);
      rx_serial  = 1'b1;
      wait_clks(5);
      check_eq("glitch_in_start", o_dbg_state, ST_START);
      wait_clks(100);
      check_eq("glitch_idle", o_dbg_state, ST_IDLE);
      check_eq("glitch_no_valid", n_valid_cyc - base_valid, 0);
      check_eq("glitch_ferr", n_ferr, exp_ferr);

      // framing error followed by a break
      base_valid = n_valid_cyc;
      uart_write_byte(8'hFF, 1'b0);
      model_frame(8'hFF, 1'b0);
      wait_clks(3 * CPB);
      check_eq("brk_state", o_dbg_state, ST_BRK);
      check_eq("brk_busy", o_busy, 1'b1);
      check_eq("brk_ferr", n_ferr, exp_ferr);
      rx_serial = 1'b1;
      wait_clks(10);
      check_eq("brk_exit_idle", o_dbg_state, ST_IDLE);
      check_eq("brk_ferr_once", n_ferr, exp_ferr);
      check_eq("brk_no_valid", n_valid_cyc - base_valid, 0);

      // reset mid-frame clears the held byte and aborts the frame
      uart_write_byte(8'h9A, 1'b1);
      model_frame(8'h9A, 1'b1);
      wait_clks(5);
      check_eq("hold_valid", o_valid, 1'b1);
      check_eq("hold_data", o_data, m_data);
      rb        = 8'h55;
      rx_serial = 1'b0;
      wait_clks(CPB);
      for (int i = 0; i < 4; i++) begin
         rx_serial = rb[i];
         wait_clks(CPB);
      end
      rx_serial = rb[4];
      wait_clks(HALF);
      RST = 1'b1;
      wait_clks(1);
      RST = 1'b0;
      m_full = 1'b0;
      void'(exp_q.pop_back());
      wait_clks(2);
      check_eq("abort_valid", o_valid, 1'b0);
      check_eq("abort_data", o_data, 8'h00);
      check_eq("abort_busy", o_busy, 1'b0);
      rx_serial  = 1'b1;
      base_valid = n_valid_cyc;
      wait_clks(12 * CPB);
      check_eq("abort_no_output", n_valid_cyc - base_valid, 0);
      i_ready = 1'b1;
      uart_write_byte(8'h55, 1'b1);
      model_frame(8'h55, 1'b1);
      m_full = 1'b0;
      wait_clks(5);
      i_ready = 1'b0;
      score_all("resend");

      // randomized frames, stop errors and drain decisions
      for (int f = 0; f < 10; f++) begin
         if ($urandom_range(0, 1) == 1) pulse_ready();
         rb    = 8'($urandom_range(0, 255));
         rstop = ($urandom_range(0, 4) != 0);
         uart_write_byte(rb, rstop);
         model_frame(rb, rstop);
         rx_serial = 1'b1;
         wait_clks($urandom_range(4, 30));
      end
      wait_clks(5);
      pulse_ready();
      wait_clks(3);
      check_eq("rand_drained", o_valid, 1'b0);
      check_eq("rand_ferr", n_ferr, exp_ferr);
      check_eq("rand_ovr", n_ovr, exp_ovr);
      score_all("rand");

      check_eq("flags_exclusive", n_both, 0);
      check_eq("hold_stable", n_unstable, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
